// File: rtl/match_ranker.sv
// match_ranker: keeps a sorted top-DEPTH list of candidates ranked by
// squared trace-overlap distance (larger dist2 = closer match).
//
// Parameters:
//   NUMBER_BITS  numeric width used by the distance calculator (mirrors types.svi)
//   DIST_BITS    distance width, defaults to the calculator output width
//   ID_BITS      candidate ID width and accepted-candidate counter width
//   DEPTH        number of ranked slots (1..8)
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start                    clears the table and begins a search
//   cand_valid/dist/id/last  candidate result from the distance stage
//   threshold                early-exit level (MATCH_THRESHOLD_EN only)
//   best_dist/id/valid       ranked table, slot 0 is the best
//   count                    accepted candidates this search, saturating
//   busy                     high while searching
//   done                     one-cycle pulse when a search ends
//   hit                      sticky threshold-reached flag
//
// Optional feature: define MATCH_THRESHOLD_EN to enable the threshold
// early exit. Without it the threshold port is absent and hit is tied low.
module match_ranker #(
    parameter int unsigned NUMBER_BITS = 8,
    parameter int unsigned DIST_BITS   = 2 * (NUMBER_BITS + 3) + 1,
    parameter int unsigned ID_BITS     = 16,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cand_valid,
    input  logic [DIST_BITS-1:0] cand_dist,
    input  logic [ID_BITS-1:0]   cand_id,
    input  logic                 cand_last,
`ifdef MATCH_THRESHOLD_EN
    input  logic [DIST_BITS-1:0] threshold,
`endif
    output logic [DIST_BITS-1:0] best_dist  [DEPTH],
    output logic [ID_BITS-1:0]   best_id    [DEPTH],
    output logic                 best_valid [DEPTH],
    output logic [ID_BITS-1:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic                 hit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DIST_BITS-1:0] dist_q  [DEPTH];
    logic [DIST_BITS-1:0] dist_d  [DEPTH];
    logic [ID_BITS-1:0]   id_q    [DEPTH];
    logic [ID_BITS-1:0]   id_d    [DEPTH];
    logic                 valid_q [DEPTH];
    logic                 valid_d [DEPTH];
    logic [ID_BITS-1:0]   count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 placed;
    logic                 end_search;
`ifdef MATCH_THRESHOLD_EN
    logic                 hit_q, hit_d;
`endif

    // Next-state, parallel compare-and-shift insertion, counters.
    always_comb begin
        state_d    = state_q;
        dist_d     = dist_q;
        id_d       = id_q;
        valid_d    = valid_q;
        count_d    = count_q;
        done_d     = 1'b0;
        placed     = 1'b0;
        end_search = 1'b0;
`ifdef MATCH_THRESHOLD_EN
        hit_d      = hit_q;
`endif

        if (start) begin
            // start wins over a same-cycle candidate and restarts from any state
            state_d = ST_SEARCH;
            count_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dist_d[i]  = '0;
                id_d[i]    = '0;
                valid_d[i] = 1'b0;
            end
`ifdef MATCH_THRESHOLD_EN
            hit_d = 1'b0;
`endif
        end else if ((state_q == ST_SEARCH) && cand_valid) begin
            // Strict compare: an equal distance lands below the earlier entry.
            placed = !valid_q[0] || (dist_q[0] < cand_dist);
            if (placed) begin
                dist_d[0]  = cand_dist;
                id_d[0]    = cand_id;
                valid_d[0] = 1'b1;
            end
            // Slots after the insertion point take their upper neighbour.
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (placed) begin
                    dist_d[i]  = dist_q[i-1];
                    id_d[i]    = id_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end else if (!valid_q[i] || (dist_q[i] < cand_dist)) begin
                    dist_d[i]  = cand_dist;
                    id_d[i]    = cand_id;
                    valid_d[i] = 1'b1;
                    placed     = 1'b1;
                end
            end

            if (count_q != '1) begin
                count_d = count_q + ID_BITS'(1);
            end

            end_search = cand_last;
`ifdef MATCH_THRESHOLD_EN
            if (cand_dist >= threshold) begin
                hit_d      = 1'b1;
                end_search = 1'b1;
            end
`endif
            if (end_search) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d == ST_SEARCH);
    end

    // State and table registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dist_q[i]  <= '0;
                id_q[i]    <= '0;
                valid_q[i] <= 1'b0;
            end
`ifdef MATCH_THRESHOLD_EN
            hit_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dist_q  <= dist_d;
            id_q    <= id_d;
            valid_q <= valid_d;
`ifdef MATCH_THRESHOLD_EN
            hit_q   <= hit_d;
`endif
        end
    end

    assign best_dist  = dist_q;
    assign best_id    = id_q;
    assign best_valid = valid_q;
    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef MATCH_THRESHOLD_EN
    assign hit        = hit_q;
`else
    assign hit        = 1'b0;
`endif

endmodule

// File: tb/tb_match_ranker.sv
// tb_match_ranker: self-checking bench for match_ranker. A sorted-queue
// reference model predicts the table; a second narrow instance exercises
// counter saturation.
module tb_match_ranker;

    localparam int unsigned NB  = 8;
    localparam int unsigned DW  = 2 * (NB + 3) + 1;
    localparam int unsigned IW  = 16;
    localparam int unsigned DEP = 4;
    localparam int unsigned SIW = 3;
    localparam int unsigned SDP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cand_valid;
    logic [DW-1:0] cand_dist;
    logic [IW-1:0] cand_id;
    logic          cand_last;
`ifdef MATCH_THRESHOLD_EN
    logic [DW-1:0] threshold;
`endif
    logic [DW-1:0] best_dist  [DEP];
    logic [IW-1:0] best_id    [DEP];
    logic          best_valid [DEP];
    logic [IW-1:0] count;
    logic          busy, done, hit;

    logic [DW-1:0]  sat_best_dist  [SDP];
    logic [SIW-1:0] sat_best_id    [SDP];
    logic           sat_best_valid [SDP];
    logic [SIW-1:0] sat_count;
    logic           sat_busy, sat_done, sat_hit;

    match_ranker #(.NUMBER_BITS(NB), .ID_BITS(IW), .DEPTH(DEP)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cand_valid (cand_valid),
        .cand_dist  (cand_dist),
        .cand_id    (cand_id),
        .cand_last  (cand_last),
`ifdef MATCH_THRESHOLD_EN
        .threshold  (threshold),
`endif
        .best_dist  (best_dist),
        .best_id    (best_id),
        .best_valid (best_valid),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .hit        (hit)
    );

    match_ranker #(.NUMBER_BITS(NB), .ID_BITS(SIW), .DEPTH(SDP)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cand_valid (cand_valid),
        .cand_dist  (cand_dist),
        .cand_id    (cand_id[SIW-1:0]),
        .cand_last  (cand_last),
`ifdef MATCH_THRESHOLD_EN
        .threshold  (threshold),
`endif
        .best_dist  (sat_best_dist),
        .best_id    (sat_best_id),
        .best_valid (sat_best_valid),
        .count      (sat_count),
        .busy       (sat_busy),
        .done       (sat_done),
        .hit        (sat_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: descending queue, new entries go below equal ones.
    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_count;
    bit          m_search, m_done, m_hit;
    logic [DW-1:0] m_thr;

    function automatic void mdl_clear();
        mq.delete();
        m_count = 0;
        m_hit   = 0;
    endfunction

    function automatic void mdl_accept(input logic [DW-1:0] d, input logic [IW-1:0] id,
                                       input bit last);
        int   p;
        ent_t e;
        m_done = 0;
        if (!m_search) return;
        p = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].d < d) begin
                p = i;
                break;
            end
        end
        if (p < int'(DEP)) begin
            e.d  = d;
            e.id = id;
            mq.insert(p, e);
            if (mq.size() > int'(DEP)) void'(mq.pop_back());
        end
        if (m_count < (2 ** IW) - 1) m_count++;
`ifdef MATCH_THRESHOLD_EN
        if (d >= m_thr) begin
            m_hit = 1;
            last  = 1;
        end
`endif
        if (last) begin
            m_search = 0;
            m_done   = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset    = 1'b0;
        mdl_clear();
        m_search = 0;
        m_done   = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start    = 1'b0;
        mdl_clear();
        m_search = 1;
        m_done   = 0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id, input bit last);
        cand_valid = 1'b1;
        cand_dist  = d;
        cand_id    = id;
        cand_last  = last;
        mdl_accept(d, id, last);
        tick();
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic test_reset();
        cand_dist = '0;
        cand_id   = '0;
        do_reset();
        checks++;
        if ({busy, done, hit} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b hit=%b expected 000", busy, done, hit);
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        for (int i = 0; i < int'(DEP); i++) begin
            checks++;
            if (best_valid[i] !== 1'b0 || best_dist[i] !== '0 || best_id[i] !== '0) begin
                errors++;
                $display("FAIL reset_slot%0d: got v=%b d=%0d id=%0d expected 0/0/0",
                         i, best_valid[i], best_dist[i], best_id[i]);
            end
        end
    endtask

    task automatic test_directed();
        int dl[5] = '{5, 9, 2, 9, 7};
        int ed[4] = '{9, 9, 7, 5};
        int ei[4] = '{2, 4, 5, 1};
        do_start();
        for (int k = 0; k < 5; k++) begin
            send(DW'(dl[k]), IW'(k + 1), k == 4);
            checks++;
            if (done !== (k == 4)) begin
                errors++;
                $display("FAIL directed_done_%0d: got %b expected %b", k, done, k == 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (best_dist[i] !== DW'(ed[i]) || best_id[i] !== IW'(ei[i]) || best_valid[i] !== 1'b1) begin
                errors++;
                $display("FAIL directed_slot%0d: got d=%0d id=%0d v=%b expected d=%0d id=%0d v=1",
                         i, best_dist[i], best_id[i], best_valid[i], ed[i], ei[i]);
            end
        end
        checks++;
        if (count !== IW'(5) || busy !== 1'b0) begin
            errors++;
            $display("FAIL directed_count_busy: got count=%0d busy=%b expected 5/0", count, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL directed_done_width: got %b expected 0", done);
        end
    endtask

    task automatic test_partial();
        int ed[4] = '{8, 4, 1, 0};
        do_start();
        send(DW'(4), IW'(1), 0);
        send(DW'(1), IW'(2), 0);
        send(DW'(8), IW'(3), 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (best_valid[i] !== (i < 3) || best_dist[i] !== DW'(ed[i])) begin
                errors++;
                $display("FAIL partial_slot%0d: got v=%b d=%0d expected v=%b d=%0d",
                         i, best_valid[i], best_dist[i], i < 3, ed[i]);
            end
        end
    endtask

    task automatic test_start_collision();
        start      = 1'b1;
        cand_valid = 1'b1;
        cand_dist  = DW'(100);
        cand_id    = IW'(9);
        tick();
        idle_inputs();
        mdl_clear();
        m_search = 1;
        checks++;
        if (best_valid[0] !== 1'b0 || best_dist[0] !== '0 || count !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collision: got v0=%b d0=%0d count=%0d busy=%b expected 0/0/0/1",
                     best_valid[0], best_dist[0], count, busy);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        cand_valid = 1'b1;
        cand_dist  = DW'(100);
        cand_id    = IW'(3);
        cand_last  = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (count !== '0 || best_valid[0] !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_idle: got count=%0d v0=%b done=%b busy=%b expected 0/0/0/0",
                     count, best_valid[0], done, busy);
        end
        do_start();
        send(DW'(20), IW'(7), 1);
        send(DW'(100), IW'(8), 1);
        checks++;
        if (count !== IW'(1) || best_dist[0] !== DW'(20) || best_id[0] !== IW'(7) || done !== 1'b0) begin
            errors++;
            $display("FAIL ignored_done: got count=%0d d0=%0d id0=%0d done=%b expected 1/20/7/0",
                     count, best_dist[0], best_id[0], done);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        send(DW'(30), IW'(1), 0);
        send(DW'(40), IW'(2), 0);
        cand_valid = 1'b1;
        cand_last  = 1'b1;
        do_reset();
        checks++;
        if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 ||
            best_valid[0] !== 1'b0 || best_valid[1] !== 1'b0 || best_dist[0] !== '0 || best_id[1] !== '0) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d busy=%b done=%b v0=%b v1=%b d0=%0d expected all 0",
                     count, busy, done, best_valid[0], best_valid[1], best_dist[0]);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_saturation();
        do_start();
        for (int k = 0; k < 10; k++) send(DW'(k), IW'(k), 0);
        checks++;
        if (sat_count !== SIW'(7) || count !== IW'(10)) begin
            errors++;
            $display("FAIL saturation: got sat_count=%0d count=%0d expected 7/10", sat_count, count);
        end
        checks++;
        if (sat_best_dist[0] !== DW'(9) || sat_best_dist[1] !== DW'(8) || sat_best_id[0] !== SIW'(1) ||
            sat_best_valid[1] !== 1'b1 || sat_busy !== 1'b1 || sat_done !== 1'b0 || sat_hit !== 1'b0) begin
            errors++;
            $display("FAIL saturation_table: got d0=%0d d1=%0d id0=%0d v1=%b busy=%b done=%b hit=%b expected 9/8/1/1/1/0/0",
                     sat_best_dist[0], sat_best_dist[1], sat_best_id[0], sat_best_valid[1],
                     sat_busy, sat_done, sat_hit);
        end
        send(DW'(1), IW'(1), 1);
    endtask

    task automatic test_random();
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int cyc = 0; cyc < 60; cyc++) begin
                start      = (cyc == 0) || ($urandom_range(0, 24) == 0);
                cand_valid = (run < 4) ? 1'b1 : 1'(($urandom_range(0, 2) != 0));
                cand_dist  = (run % 2 == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
                cand_id    = IW'($urandom);
                cand_last  = ($urandom_range(0, 14) == 0);
                m_done = 0;
                if (start) begin
                    mdl_clear();
                    m_search = 1;
                end else if (cand_valid) begin
                    mdl_accept(cand_dist, cand_id, cand_last);
                end
                tick();
                for (int i = 0; i < int'(DEP); i++) begin
                    checks++;
                    if (best_valid[i] !== (i < mq.size()) ||
                        best_dist[i] !== ((i < mq.size()) ? mq[i].d : DW'(0)) ||
                        best_id[i] !== ((i < mq.size()) ? mq[i].id : IW'(0))) begin
                        errors++;
                        $display("FAIL random_slot%0d run%0d cyc%0d: got v=%b d=%0d id=%0d expected v=%b d=%0d id=%0d",
                                 i, run, cyc, best_valid[i], best_dist[i], best_id[i], i < mq.size(),
                                 (i < mq.size()) ? mq[i].d : DW'(0), (i < mq.size()) ? mq[i].id : IW'(0));
                    end
                end
                checks++;
                if (count !== IW'(m_count) || busy !== m_search || done !== m_done || hit !== m_hit) begin
                    errors++;
                    $display("FAIL random_ctl run%0d cyc%0d: got count=%0d busy=%b done=%b hit=%b expected %0d/%b/%b/%b",
                             run, cyc, count, busy, done, hit, m_count, m_search, m_done, m_hit);
                end
            end
            idle_inputs();
        end
    endtask

`ifdef MATCH_THRESHOLD_EN
    task automatic test_threshold();
        threshold = DW'(50);
        m_thr     = DW'(50);
        do_start();
        send(DW'(10), IW'(1), 0);
        checks++;
        if (hit !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL thr_below: got hit=%b done=%b busy=%b expected 0/0/1", hit, done, busy);
        end
        send(DW'(60), IW'(2), 0);
        checks++;
        if (hit !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL thr_hit: got hit=%b done=%b busy=%b expected 1/1/0", hit, done, busy);
        end
        send(DW'(70), IW'(3), 0);
        checks++;
        if (best_dist[0] !== DW'(60) || count !== IW'(2) || hit !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL thr_after: got d0=%0d count=%0d hit=%b done=%b expected 60/2/1/0",
                     best_dist[0], count, hit, done);
        end
        do_start();
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL thr_clear: got hit=%b expected 0", hit);
        end
        threshold = '1;
        m_thr     = '1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_thr    = '1;
        m_search = 0;
        m_done   = 0;
`ifdef MATCH_THRESHOLD_EN
        threshold = '1;
`endif
        test_reset();
        test_directed();
        test_partial();
        test_start_collision();
        test_ignored();
        test_reset_mid();
        test_saturation();
        test_random();
`ifdef MATCH_THRESHOLD_EN
        test_threshold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
